// File: rtl/mix_columns_ark.sv
`default_nettype none
// ============================================================================
// Module  : mix_columns_ark
// Brief   : Iterative AES MixColumns + AddRoundKey stage, valid/ready both sides
// Revision: 1.0 - initial release
// ============================================================================

module mix_columns_ark #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic [0:127] in_round_key,
  input  logic         in_last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_busy  = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
  // Step wraps to 0 for four columns; the counter is reloaded on every accept.
  localparam logic [1:0] c_col_step = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] c_col_last = 2'(4 - COLS_PER_CYCLE);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_ark: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  logic [1:0]   r_st;
  logic [1:0]   w_st_next;
  logic [1:0]   r_col;
  logic [0:127] r_state;
  logic [0:127] r_key;
  logic         r_last;
  logic         w_accept;
  logic [1:0]   w_lane_idx [COLS_PER_CYCLE];
  logic [0:31]  w_lane_res [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [0:31] mix_col(input logic [0:31] s);
    logic [7:0] s0, s1, s2, s3;
    s0 = s[0:7];
    s1 = s[8:15];
    s2 = s[16:23];
    s3 = s[24:31];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= c_st_idle;
    else        r_st <= w_st_next;
  end

  // Next-state logic
  always_comb begin
    w_st_next = r_st;
    case (r_st)
      c_st_idle: if (in_valid) w_st_next = c_st_busy;
      c_st_busy: if (r_col == c_col_last) w_st_next = c_st_done;
      c_st_done: if (out_ready) w_st_next = in_valid ? c_st_busy : c_st_idle;
      default:   w_st_next = c_st_idle;
    endcase
  end

  // Outputs decoded from state only, apart from the documented in_ready path
  always_comb begin
    in_ready  = (r_st == c_st_idle) | ((r_st == c_st_done) & out_ready);
    out_valid = (r_st == c_st_done);
  end

  assign w_accept = in_valid & in_ready;

  generate
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
      logic [0:31] w_col_in;
      logic [0:31] w_col_key;
      assign w_lane_idx[j] = r_col + 2'(j);
      assign w_col_in      = r_state[{w_lane_idx[j], 5'b0} +: 32];
      assign w_col_key     = r_key[{w_lane_idx[j], 5'b0} +: 32];
      assign w_lane_res[j] = (r_last ? w_col_in : mix_col(w_col_in)) ^ w_col_key;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_key     <= '0;
      r_last    <= 1'b0;
      r_col     <= 2'd0;
      out_state <= '0;
    end else if (w_accept) begin
      r_state <= in_state;
      r_key   <= in_round_key;
      r_last  <= in_last_round;
      r_col   <= 2'd0;
    end else if (r_st == c_st_busy) begin
      r_col <= r_col + c_col_step;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        out_state[{w_lane_idx[j], 5'b0} +: 32] <= w_lane_res[j];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_ark.sv
`default_nettype none
// ============================================================================
// Module  : tb_mix_columns_ark
// Brief   : Directed and streamed vectors for mix_columns_ark (one column/cycle)
// Revision: 1.0 - initial release
// ============================================================================

module tb_mix_columns_ark;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_round_key;
  logic         in_last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mix_columns_ark #(.COLS_PER_CYCLE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_state     (in_state),
    .in_round_key (in_round_key),
    .in_last_round(in_last_round),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_state    (out_state)
  );

  // Independent reference: generic GF(2^8) multiply and coefficient matrix
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1B;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic last);
    logic [127:0] res;
    logic [7:0]   acc;
    logic [7:0]   coef;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (last) begin
          acc = s[127 - 8*(4*c + r) -: 8];
        end else begin
          acc = 8'h00;
          for (int i = 0; i < 4; i++) begin
            case ((i - r + 4) % 4)
              0:       coef = 8'h02;
              1:       coef = 8'h03;
              default: coef = 8'h01;
            endcase
            acc = acc ^ gmul(coef, s[127 - 8*(4*c + i) -: 8]);
          end
        end
        res[127 - 8*(4*c + r) -: 8] = acc ^ k[127 - 8*(4*c + r) -: 8];
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic last);
    int ok;
    in_state      = s;
    in_round_key  = k;
    in_last_round = last;
    in_valid      = 1'b1;
    ok            = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    check("accept", 128'(ok), 128'd1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("out_valid_timeout", 128'(out_valid), 128'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_take", 128'(out_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_v;
    logic [127:0] blk_b;
    logic [127:0] key_b;
    logic [127:0] exp_q [$];
    int           n;
    int           last_ho;
    int           n_out;
    int           seen;
    logic         acc;

    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_state      = '0;
    in_round_key  = '0;
    in_last_round = 1'b0;
    out_ready     = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_state", out_state, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;
    tick();

    // Single FIPS-197 column
    send(128'hdb135345_00000000_00000000_00000000, '0, 1'b0);
    wait_out(n);
    check("col0_latency", 128'(n), 128'd4);
    check("col0_data", out_state, 128'h8e4da1bc_00000000_00000000_00000000);
    drain();

    // FIPS-197 Appendix B round 1
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, '0, 1'b0);
    wait_out(n);
    check("appb_latency", 128'(n), 128'd4);
    check("appb_data", out_state, 128'h046681e5e0cb199a48f8d37a2806264c);
    drain();

    // Last round: key of all ones inverts the state
    send(128'h00112233445566778899aabbccddeeff, {128{1'b1}}, 1'b1);
    wait_out(n);
    check("last_latency", 128'(n), 128'd4);
    check("last_data", out_state, 128'hffeeddccbbaa99887766554433221100);
    drain();

    // Backpressure in DONE, then same-cycle handoff to the next block
    send(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    wait_out(n);
    exp_v = 128'h046681e5e0cb199a48f8d37a2806264c;
    exp_v = model(128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    blk_b = 128'hd4e0b81ebfb441275d52119830aef1e5;
    key_b = 128'ha0fafe1788542cb123a339392a6c7605;
    in_state      = blk_b;
    in_round_key  = key_b;
    in_last_round = 1'b0;
    in_valid      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_state", out_state, exp_v);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 128'(in_ready), 128'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_busy_out_valid", 128'(out_valid), 128'd0);
    check("bp_busy_in_ready", 128'(in_ready), 128'd0);
    wait_out(n);
    check("bp_next_latency", 128'(n), 128'd4);
    check("bp_next_data", out_state, model(blk_b, key_b, 1'b0));
    drain();

    // Streaming: full throughput against the reference model
    out_ready     = 1'b1;
    in_valid      = 1'b1;
    in_state      = {$urandom, $urandom, $urandom, $urandom};
    in_round_key  = {$urandom, $urandom, $urandom, $urandom};
    in_last_round = 1'($urandom_range(0, 1));
    last_ho       = -1;
    n_out         = 0;
    for (int cyc = 0; cyc < 300 && n_out < 20; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_output", out_state, 128'hx);
        end else begin
          check("stream_data", out_state, exp_q.pop_front());
        end
        if (last_ho >= 0) check("stream_interval", 128'(cyc - last_ho), 128'd5);
        last_ho = cyc;
        n_out++;
      end
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(model(in_state, in_round_key, in_last_round));
      tick();
      if (acc) begin
        in_state      = {$urandom, $urandom, $urandom, $urandom};
        in_round_key  = {$urandom, $urandom, $urandom, $urandom};
        in_last_round = 1'($urandom_range(0, 1));
      end
    end
    check("stream_count", 128'(n_out), 128'd20);

    // The last handshake also accepted a block: abort it mid-BUSY with reset
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 128'(out_valid), 128'd0);
    check("async_rst_out_state", out_state, 128'd0);
    tick();
    rst_n = 1'b1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    check("aborted_block_hidden", 128'(seen), 128'd0);

    send(blk_b, key_b, 1'b1);
    wait_out(n);
    check("post_rst_latency", 128'(n), 128'd4);
    check("post_rst_data", out_state, model(blk_b, key_b, 1'b1));
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
